// File: rtl/alu_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared definitions for the ALU issue/writeback controller:
//   - ALU select codes (3-bit select of the external 8-bit registered ALU)
//   - command opcode layout (bit 3 = LOAD immediate, bits 2:0 = ALU select)
//   - controller FSM state encoding
// ---------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int OP_W       = 4;
    localparam int SEL_W      = 3;
    localparam int OP_LOAD    = 3;

    typedef enum logic [SEL_W-1:0] {
        SEL_ADD  = 3'd0,
        SEL_SUB  = 3'd1,
        SEL_IDEN = 3'd2,
        SEL_LS   = 3'd3,
        SEL_RS   = 3'd4,
        SEL_AND  = 3'd5,
        SEL_NOT  = 3'd6,
        SEL_OR   = 3'd7
    } alu_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WB    = 2'd2
    } state_e;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return op[OP_LOAD];
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
// Command channel into the issue controller (valid/ready handshake).
//   cmd_valid  source -> ctrl  command present
//   cmd_ready  ctrl -> source  controller can accept
//   cmd_op     source -> ctrl  [3]=LOAD imm, [2:0]=ALU select
//   cmd_rd     source -> ctrl  destination register
//   cmd_rs1    source -> ctrl  ALU in1 source register
//   cmd_rs2    source -> ctrl  ALU in2 source register
//   cmd_imm    source -> ctrl  LOAD data
// master = command source, slave = controller.
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if #(
    parameter int AW     = 2,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [AW-1:0]     cmd_rd;
    logic [AW-1:0]     cmd_rs1;
    logic [AW-1:0]     cmd_rs2;
    logic [DATA_W-1:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_regfile
// NUM_REGS x DATA_W register file: one synchronous write port, three
// asynchronous read ports, asynchronous active-low clear.
//   clk, rst_n          clock / async clear
//   we, waddr, wdata    write port (posedge)
//   raddr0..2/rdata0..2 combinational read ports (no write bypass)
// ---------------------------------------------------------------------------
module alu_issue_ctrl_regfile #(
    parameter int NUM_REGS = 4,
    parameter int AW       = 2,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr0,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata0 = r_mem[raddr0];
    assign rdata1 = r_mem[raddr1];
    assign rdata2 = r_mem[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issue/writeback controller for an external 8-bit registered ALU.
// Accepts one command at a time, reads operands from its register file,
// drives the ALU for one cycle, and writes the ALU's registered result
// (or a LOAD immediate) back to the register file.
//   clk, rst_n     clock / async active-low reset
//   cmd            command channel (slave side)
//   alu_in1/2      ALU operands, zero outside ISSUE
//   alu_select     ALU select, zero outside ISSUE
//   alu_result     ALU registered result, sampled only in WB
//   done           one-cycle pulse after each writeback
//   wb_data        last written value (held)
//   wb_zero        wb_data == 0 (held)
//   op_count       completed commands, saturating
//   rf_raddr/rdata debug read port, no write bypass
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_ctrl_if.slave      cmd,
    output logic [DATA_W-1:0]    alu_in1,
    output logic [DATA_W-1:0]    alu_in2,
    output logic [SEL_W-1:0]     alu_select,
    input  logic [DATA_W-1:0]    alu_result,
    output logic                 done,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 wb_zero,
    output logic [CNT_W-1:0]     op_count,
    input  logic [AW-1:0]        rf_raddr,
    output logic [DATA_W-1:0]    rf_rdata
);

    state_e            r_state;
    state_e            w_state_nxt;

    logic [OP_W-1:0]   r_op;
    logic [AW-1:0]     r_rd;
    logic [AW-1:0]     r_rs1;
    logic [AW-1:0]     r_rs2;
    logic [DATA_W-1:0] r_imm;

    logic              r_done;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_wb_zero;
    logic [CNT_W-1:0]  r_op_count;

    logic              w_accept;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    alu_sel_e          w_sel;

    alu_issue_ctrl_regfile #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW),
        .DATA_W   (DATA_W)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (w_we),
        .waddr  (r_rd),
        .wdata  (w_wdata),
        .raddr0 (r_rs1),
        .raddr1 (r_rs2),
        .raddr2 (rf_raddr),
        .rdata0 (w_rs1_data),
        .rdata1 (w_rs2_data),
        .rdata2 (rf_rdata)
    );

    assign w_accept = (r_state == ST_IDLE) && cmd.cmd_valid;
    assign w_sel    = alu_sel_e'(r_op[SEL_W-1:0]);
    // LOAD bypasses the ALU entirely; ALU ops take the result registered at the ISSUE edge.
    assign w_wdata  = is_load(r_op) ? r_imm : alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        cmd.cmd_ready = 1'b0;
        alu_in1       = '0;
        alu_in2       = '0;
        alu_select    = '0;
        w_we          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    w_state_nxt = is_load(cmd.cmd_op) ? ST_WB : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_in1     = w_rs1_data;
                alu_in2     = w_rs2_data;
                alu_select  = w_sel;
                w_state_nxt = ST_WB;
            end
            ST_WB: begin
                w_we        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_rd  <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_imm <= '0;
        end else if (w_accept) begin
            r_op  <= cmd.cmd_op;
            r_rd  <= cmd.cmd_rd;
            r_rs1 <= cmd.cmd_rs1;
            r_rs2 <= cmd.cmd_rs2;
            r_imm <= cmd.cmd_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done     <= 1'b0;
            r_wb_data  <= '0;
            r_wb_zero  <= 1'b1;
            r_op_count <= '0;
        end else begin
            r_done <= w_we;
            if (w_we) begin
                r_wb_data <= w_wdata;
                r_wb_zero <= (w_wdata == '0);
                if (r_op_count != '1) begin
                    r_op_count <= r_op_count + 1'b1;
                end
            end
        end
    end

    assign done     = r_done;
    assign wb_data  = r_wb_data;
    assign wb_zero  = r_wb_zero;
    assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int AWID  = 2;
    localparam int CW    = 3;   // small counter so saturation is reached

    logic            clk;
    logic            rst_n;
    logic [DW-1:0]   alu_in1;
    logic [DW-1:0]   alu_in2;
    logic [2:0]      alu_select;
    logic [DW-1:0]   alu_result;
    logic            done;
    logic [DW-1:0]   wb_data;
    logic            wb_zero;
    logic [CW-1:0]   op_count;
    logic [AWID-1:0] rf_raddr;
    logic [DW-1:0]   rf_rdata;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_rf [NR];
    logic [CW-1:0] m_cnt;

    alu_issue_ctrl_if #(.AW(AWID), .DATA_W(DW)) cmd_if ();

    alu_issue_ctrl #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .AW       (AWID),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd_if.slave),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_select (alu_select),
        .alu_result (alu_result),
        .done       (done),
        .wb_data    (wb_data),
        .wb_zero    (wb_zero),
        .op_count   (op_count),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External registered ALU, no reset.
    function automatic logic [DW-1:0] alu_f(input logic [2:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (s)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a;
            3'd3: return a << 1;
            3'd4: return a >> 1;
            3'd5: return a & b;
            3'd6: return ~a;
            default: return a | b;
        endcase
    endfunction

    always @(posedge clk) alu_result <= alu_f(alu_select, alu_in1, alu_in2);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bump_cnt();
        if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
    endtask

    // Issues one command from IDLE and checks the full cycle-by-cycle sequence.
    task automatic do_cmd(input string tag, input logic [3:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [7:0] imm, input logic [7:0] exp_v);
        @(negedge clk);
        check({tag, " ready_idle"}, cmd_if.cmd_ready, 1);
        check({tag, " alu_idle"}, {alu_in1, alu_in2, alu_select}, 0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_rd    = rd;
        cmd_if.cmd_rs1   = rs1;
        cmd_if.cmd_rs2   = rs2;
        cmd_if.cmd_imm   = imm;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        if (!op[3]) begin
            check({tag, " issue_in1"}, alu_in1, m_rf[rs1]);
            check({tag, " issue_in2"}, alu_in2, m_rf[rs2]);
            check({tag, " issue_sel"}, alu_select, op[2:0]);
            check({tag, " issue_ready"}, cmd_if.cmd_ready, 0);
            check({tag, " issue_done"}, done, 0);
            @(posedge clk);
            #1;
        end
        check({tag, " wb_ready"}, cmd_if.cmd_ready, 0);
        check({tag, " wb_alu_zero"}, {alu_in1, alu_in2, alu_select}, 0);
        check({tag, " wb_done"}, done, 0);
        rf_raddr = rd;
        #1;
        check({tag, " wb_nobypass"}, rf_rdata, m_rf[rd]);
        @(posedge clk);
        #1;
        m_rf[rd] = exp_v;
        bump_cnt();
        check({tag, " done"}, done, 1);
        check({tag, " wb_data"}, wb_data, exp_v);
        check({tag, " wb_zero"}, wb_zero, (exp_v == 8'h00));
        check({tag, " op_count"}, op_count, m_cnt);
        check({tag, " rf_rd"}, rf_rdata, exp_v);
        @(posedge clk);
        #1;
        check({tag, " done_low"}, done, 0);
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        sweep_exp[0] = 8'hB4; sweep_exp[1] = 8'h96; sweep_exp[2] = 8'hA5; sweep_exp[3] = 8'h4A;
        sweep_exp[4] = 8'h52; sweep_exp[5] = 8'h05; sweep_exp[6] = 8'h5A; sweep_exp[7] = 8'hAF;
        for (int i = 0; i < NR; i++) m_rf[i] = '0;
        m_cnt = '0;
        rst_n            = 1'b0;
        rf_raddr         = '0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_rd    = '0;
        cmd_if.cmd_rs1   = '0;
        cmd_if.cmd_rs2   = '0;
        cmd_if.cmd_imm   = '0;
        #12;
        check("rst ready", cmd_if.cmd_ready, 1);
        check("rst done", done, 0);
        check("rst wb_data", wb_data, 0);
        check("rst wb_zero", wb_zero, 1);
        check("rst op_count", op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Reset mid-ISSUE discards the command.
        do_cmd("t1_load", 4'b1000, 2'd1, 2'd0, 2'd0, 8'h33, 8'h33);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 4'b0000;
        cmd_if.cmd_rd    = 2'd2;
        cmd_if.cmd_rs1   = 2'd1;
        cmd_if.cmd_rs2   = 2'd1;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        check("t1 in_issue", alu_in1, 8'h33);
        rst_n = 1'b0;
        #1;
        check("t1 rst_ready", cmd_if.cmd_ready, 1);
        check("t1 rst_alu", alu_in1, 0);
        check("t1 rst_count", op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("t1 no_done", done, 0);
        end
        check("t1 ready_after", cmd_if.cmd_ready, 1);
        check("t1 wb_data", wb_data, 0);
        for (int i = 0; i < NR; i++) begin
            rf_raddr = i[1:0];
            #1;
            check("t1 rf_clear", rf_rdata, 0);
            m_rf[i] = '0;
        end
        m_cnt = '0;

        // 2. LOAD, LOAD, ADD with 8-bit truncation.
        do_cmd("t2_ld0", 4'b1000, 2'd0, 2'd0, 2'd0, 8'd200, 8'd200);
        do_cmd("t2_ld1", 4'b1000, 2'd1, 2'd0, 2'd0, 8'd100, 8'd100);
        do_cmd("t2_add", 4'b0000, 2'd2, 2'd0, 2'd1, 8'hFF, 8'd44);

        // 3. SUB wraps; NOT with rd==rs1==rs2.
        do_cmd("t3_sub", 4'b0001, 2'd3, 2'd1, 2'd0, 8'h00, 8'd156);
        do_cmd("t3_not", 4'b0110, 2'd3, 2'd3, 2'd3, 8'h00, 8'd99);

        // 4. Select sweep with A5 / 0F.
        do_cmd("t4_ld0", 4'b1000, 2'd0, 2'd0, 2'd0, 8'hA5, 8'hA5);
        do_cmd("t4_ld1", 4'b1000, 2'd1, 2'd0, 2'd0, 8'h0F, 8'h0F);
        for (int s = 0; s < 8; s++) begin
            do_cmd($sformatf("t4_sel%0d", s), {1'b0, s[2:0]}, 2'd2, 2'd0, 2'd1, 8'h00, sweep_exp[s]);
        end

        // 5. cmd_valid held high: one accept per 3 cycles.
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 4'b0000;
        cmd_if.cmd_rd    = 2'd2;
        cmd_if.cmd_rs1   = 2'd0;
        cmd_if.cmd_rs2   = 2'd1;
        for (int i = 0; i < 9; i++) begin
            if (i != 0) @(negedge clk);
            check($sformatf("t5 ready%0d", i), cmd_if.cmd_ready, (i % 3 == 0));
            @(posedge clk);
            #1;
            if (i == 8) cmd_if.cmd_valid = 1'b0;
            check($sformatf("t5 done%0d", i), done, (i % 3 == 2));
            if (i % 3 == 2) bump_cnt();
        end
        m_rf[2] = 8'hB4;
        check("t5 op_count", op_count, m_cnt);
        check("t5 wb_data", wb_data, 8'hB4);
        @(posedge clk);
        #1;
        check("t5 idle_done", done, 0);
        check("t5 idle_ready", cmd_if.cmd_ready, 1);

        // 6. LOAD zero sets wb_zero; WB-cycle read shows old value.
        do_cmd("t6_ld0", 4'b1000, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00);
        check("t6 sat_count", op_count, 3'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
